// File: rtl/axis_fifo_reader_pkg.sv
// axis_fifo_pkg: types and helpers shared by the AXI-Stream FIFO reader.
//   pkt_state_e  : packet-tracking FSM state encoding (IDLE=0, PKT=1)
//   fifo_width() : width of one packed FIFO word {tdata, tkeep, tlast}
package axis_fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } pkt_state_e;

  function automatic int fifo_width(input int tdata_bytes, input int tkeep_bits);
    return tdata_bytes * 8 + tkeep_bits + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_reader_skid_buf.sv
// axis_skid_buf: 2-entry output buffer (output register + skid register).
//   clk_i, rst_i  : clock, synchronous active-high reset
//   in_valid_i    : a popped word is present on in_data_i this cycle
//   in_data_i     : popped word
//   out_ready_i   : downstream ready
//   out_valid_o   : output register holds a word
//   out_data_o    : output register contents
//   skid_valid_o  : skid register holds a word
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             skid_valid_o
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept;

  assign accept = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    if (accept) begin
      if (skid_valid_q) begin
        // skid advances; a word arriving now takes the freed skid slot
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = in_valid_i;
        if (in_valid_i) skid_data_d = in_data_i;
      end else begin
        out_valid_d = in_valid_i;
        out_data_d  = in_data_i;
      end
    end else if (!out_valid_q) begin
      out_valid_d = in_valid_i;
      out_data_d  = in_data_i;
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/axis_fifo_reader.sv
// axis_fifo_reader: drains a first-word-latency-1 FIFO onto an AXI-Stream
// master through a 2-entry buffer, tracks packet state and (optionally)
// beat/packet statistics.
//   m_axis_aclk, m_axis_areset : clock, synchronous active-high reset
//   fifo_empty, fifo_rd_en     : source FIFO status / pop request
//   fifo_data_out              : popped word {tdata, tkeep, tlast}, 1 cycle after pop
//   m_axis_t*                  : AXI-Stream master
//   in_packet                  : inside a multi-beat packet
//   pkt_cnt, beat_cnt          : accepted tlast beats / accepted beats
// Optional feature: define AXIS_FIFO_READER_STATS_EN to implement the
// counters; otherwise they read as 0 and no counter flops exist.
module axis_fifo_reader
  import axis_fifo_pkg::*;
#(
  parameter  int TDATA_WIDTH = 64,
  parameter  int TKEEP_WIDTH = 64,
  localparam int FIFO_WIDTH  = fifo_width(TDATA_WIDTH, TKEEP_WIDTH)
) (
  input  logic                     m_axis_aclk,
  input  logic                     m_axis_areset,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0]    fifo_data_out,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [TDATA_WIDTH*8-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     in_packet,
  output logic [31:0]              pkt_cnt,
  output logic [31:0]              beat_cnt
);

  logic                  out_valid;
  logic                  skid_valid;
  logic [FIFO_WIDTH-1:0] out_word;
  logic                  rd_inflight_q;
  logic                  accept;
  logic [1:0]            occ;
  logic                  rd_en;
  pkt_state_e            state_q;
  logic                  in_packet_q;

  assign accept = out_valid & m_axis_tready;
  assign occ    = 2'(out_valid) + 2'(skid_valid) + 2'(rd_inflight_q);
  // A full buffer may still pop when a beat leaves this cycle, keeping 1 beat/cycle.
  assign rd_en  = !m_axis_areset && !fifo_empty &&
                  ((occ < 2'd2) || ((occ == 2'd2) && accept));

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) rd_inflight_q <= 1'b0;
    else               rd_inflight_q <= rd_en;
  end

  axis_skid_buf #(
    .WIDTH(FIFO_WIDTH)
  ) u_buf (
    .clk_i       (m_axis_aclk),
    .rst_i       (m_axis_areset),
    .in_valid_i  (rd_inflight_q),
    .in_data_i   (fifo_data_out),
    .out_ready_i (m_axis_tready),
    .out_valid_o (out_valid),
    .out_data_o  (out_word),
    .skid_valid_o(skid_valid)
  );

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q     <= IDLE;
      in_packet_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept && !m_axis_tlast) begin
          state_q     <= PKT;
          in_packet_q <= 1'b1;
        end
        PKT: if (accept && m_axis_tlast) begin
          state_q     <= IDLE;
          in_packet_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          in_packet_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_FIFO_READER_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] beat_cnt_q;

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else if (accept) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (m_axis_tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
`else
  assign pkt_cnt  = '0;
  assign beat_cnt = '0;
`endif

  assign fifo_rd_en    = rd_en;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_word[FIFO_WIDTH-1 -: TDATA_WIDTH*8];
  assign m_axis_tkeep  = out_word[TKEEP_WIDTH:1];
  assign m_axis_tlast  = out_word[0];
  assign in_packet     = in_packet_q;

endmodule

// File: tb/tb_axis_fifo_reader.sv
// Self-checking bench for axis_fifo_reader: a behavioural source FIFO,
// a pop-order scoreboard and a packet/counter model.
module tb_axis_fifo_reader;

  localparam int TDW = 4;
  localparam int TKW = 4;
  localparam int FW  = TDW * 8 + TKW + 1;
`ifdef AXIS_FIFO_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           m_axis_areset;
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic [FW-1:0]  fifo_data_out = '0;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [TDW*8-1:0] m_axis_tdata;
  logic [TKW-1:0] m_axis_tkeep;
  logic           m_axis_tlast;
  logic           in_packet;
  logic [31:0]    pkt_cnt;
  logic [31:0]    beat_cnt;

  always #5 clk = ~clk;

  axis_fifo_reader #(
    .TDATA_WIDTH(TDW),
    .TKEEP_WIDTH(TKW)
  ) dut (
    .m_axis_aclk  (clk),
    .m_axis_areset(m_axis_areset),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data_out(fifo_data_out),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .in_packet    (in_packet),
    .pkt_cnt      (pkt_cnt),
    .beat_cnt     (beat_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source FIFO model: word appears on fifo_data_out the cycle after a pop.
  logic [FW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [FW-1:0] exp_q [$];

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= mem[rd_ptr];
      exp_q.push_back(mem[rd_ptr]);
      rd_ptr <= rd_ptr + 1;
    end
  end

  function automatic logic [FW-1:0] mk_word(input logic last);
    return {32'($urandom), 4'($urandom_range(1, 15)), last};
  endfunction

  task automatic push(input logic last);
    mem[wr_ptr % 1024] = mk_word(last);
    wr_ptr = wr_ptr + 1;
  endtask

  // Monitor / reference model
  int   cyc = 0;
  logic rst_d1 = 1'b0;
  int   acc_cnt, first_rd, first_tv, first_acc, last_acc, rd_pulses, tv_seen;
  int   fresh_idx = 0;
  bit   first_after_rst = 1'b1;
  bit   stall_prev = 1'b0;
  bit   mdl_in_pkt = 1'b0;
  logic [31:0] mdl_beats = '0;
  logic [31:0] mdl_pkts  = '0;
  logic [FW-1:0] held;
  logic [FW-1:0] beat;
  logic [FW-1:0] expw;

  assign beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};

  always @(posedge clk) begin
    rst_d1 <= m_axis_areset;
    cyc    <= cyc + 1;
  end

  always @(negedge clk) begin
    if (m_axis_areset) begin
      if (rst_d1) begin
        check_eq("rst_tvalid",    64'(m_axis_tvalid), 64'd0);
        check_eq("rst_rd_en",     64'(fifo_rd_en),    64'd0);
        check_eq("rst_in_packet", 64'(in_packet),     64'd0);
        check_eq("rst_pkt_cnt",   64'(pkt_cnt),       64'd0);
        check_eq("rst_beat_cnt",  64'(beat_cnt),      64'd0);
      end
      exp_q.delete();
      mdl_in_pkt      = 1'b0;
      mdl_beats       = '0;
      mdl_pkts        = '0;
      stall_prev      = 1'b0;
      first_after_rst = 1'b1;
    end else begin
      if (fifo_rd_en) begin
        check_eq("rd_en_while_empty", 64'(fifo_empty), 64'd0);
        rd_pulses++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_axis_tvalid) begin
        tv_seen++;
        if (first_tv < 0) first_tv = cyc;
      end
      if (stall_prev) begin
        check_eq("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
        check_eq("hold_beat",   64'(beat),          64'(held));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_beat", 64'd1, 64'd0);
        end else begin
          expw = exp_q.pop_front();
          check_eq("beat_data", 64'(beat), 64'(expw));
        end
        if (first_after_rst) begin
          check_eq("fresh_pop", 64'(beat), 64'(mem[fresh_idx % 1024]));
          first_after_rst = 1'b0;
        end
        check_eq("in_packet", 64'(in_packet), 64'(mdl_in_pkt));
        check_eq("beat_cnt",  64'(beat_cnt),  STATS ? 64'(mdl_beats) : 64'd0);
        check_eq("pkt_cnt",   64'(pkt_cnt),   STATS ? 64'(mdl_pkts)  : 64'd0);
        mdl_beats = mdl_beats + 32'd1;
        if (m_axis_tlast) begin
          mdl_pkts   = mdl_pkts + 32'd1;
          mdl_in_pkt = 1'b0;
        end else begin
          mdl_in_pkt = 1'b1;
        end
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = beat;
    end
  end

  task automatic clear_stats();
    acc_cnt   = 0;
    first_rd  = -1;
    first_tv  = -1;
    first_acc = -1;
    last_acc  = 0;
    rd_pulses = 0;
    tv_seen   = 0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (acc_cnt < n) check_eq("accept_timeout", 64'(acc_cnt), 64'(n));
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k, rd0;
    clear_stats();
    m_axis_areset = 1'b1;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_axis_areset = 1'b0;
    fresh_idx = rd_ptr;

    // Streaming: 8-word packet, tready high
    clear_stats();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) push(i == 7);
    wait_acc(8, 50);
    check_eq("stream_latency", 64'(first_tv - first_rd), 64'd2);
    check_eq("stream_consec",  64'(last_acc - first_acc), 64'd7);
    @(negedge clk);
    check_eq("stream_pkt_cnt",  64'(pkt_cnt),  STATS ? 64'd1 : 64'd0);
    check_eq("stream_beat_cnt", 64'(beat_cnt), STATS ? 64'd8 : 64'd0);
    @(posedge clk); #1;

    // Backpressure: 5 words queued, tready low for 10 cycles
    m_axis_tready = 1'b0;
    clear_stats();
    for (int i = 0; i < 5; i++) push(i == 4);
    repeat (10) @(posedge clk);
    #1;
    check_eq("bp_rd_pulses", 64'(rd_pulses), 64'd2);
    check_eq("bp_tvalid",    64'(m_axis_tvalid), 64'd1);
    m_axis_tready = 1'b1;
    wait_acc(5, 40);
    check_eq("bp_beats", 64'(acc_cnt), 64'd5);

    // Empty source
    clear_stats();
    repeat (20) @(posedge clk);
    #1;
    check_eq("empty_rd_en",  64'(rd_pulses), 64'd0);
    check_eq("empty_tvalid", 64'(tv_seen),   64'd0);

    // Alternating tready over a 6-word packet
    clear_stats();
    for (int i = 0; i < 6; i++) push(i == 5);
    k = 0;
    while (acc_cnt < 6 && k < 60) begin
      @(posedge clk);
      #1 m_axis_tready = ~m_axis_tready;
      k++;
    end
    m_axis_tready = 1'b1;
    check_eq("alt_beats", 64'(acc_cnt), 64'd6);
    repeat (3) @(posedge clk);
    #1;
    check_eq("alt_leftover",  64'(exp_q.size()), 64'd0);
    check_eq("alt_in_packet", 64'(in_packet),    64'd0);

    // Reset after 3 of 6 beats accepted
    clear_stats();
    for (int i = 0; i < 6; i++) push(i == 5);
    wait_acc(3, 30);
    m_axis_areset = 1'b1;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 m_axis_areset = 1'b0;
    clear_stats();
    fresh_idx = rd_ptr;
    push(1'b0);
    push(1'b1);
    m_axis_tready = 1'b1;
    n = wr_ptr - rd_ptr;
    wait_acc(n, 60);
    check_eq("rst_recover_beats", 64'(acc_cnt), 64'(n));
    @(negedge clk);
    check_eq("rst_recover_in_pkt", 64'(in_packet), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic
    clear_stats();
    rd0 = rd_ptr;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) push($urandom_range(0, 3) == 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    m_axis_tready = 1'b1;
    n = wr_ptr - rd0;
    wait_acc(n, 400);
    check_eq("rand_beats", 64'(acc_cnt), 64'(n));
    @(negedge clk);
    check_eq("rand_beat_cnt", 64'(beat_cnt), STATS ? 64'(mdl_beats) : 64'd0);
    check_eq("rand_pkt_cnt",  64'(pkt_cnt),  STATS ? 64'(mdl_pkts)  : 64'd0);
    @(posedge clk); #1;

`ifdef AXIS_FIFO_READER_STATS_EN
    // Counter wrap
    m_axis_tready = 1'b0;
    @(negedge clk);
    force dut.beat_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.beat_cnt_q;
    mdl_beats = 32'hFFFF_FFFE;
    clear_stats();
    push(1'b0);
    push(1'b1);
    m_axis_tready = 1'b1;
    wait_acc(2, 30);
    @(negedge clk);
    check_eq("wrap_beat_cnt", 64'(beat_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
